mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 171 +++++++++++++++++
 tb/tb_mem_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
//   Streams an image from a valid/ready source into an L1 word memory, one
//   word per cycle, starting at a programmable base address. The processing
//   unit is held while the load is in progress. A write that would run past
//   the top of the address space stops the load in an error state instead of
//   wrapping.
//
// Optional build feature:
//   MEM_LOADER_CHECKSUM_EN - adds output 'checksum', the modulo-2**DATA_WIDTH
//                            sum of all words accepted since the last start.
//
// Ports:
//   clk         in   clock, all state on its rising edge
//   reset       in   asynchronous active-low reset
//   start       in   one-cycle pulse, begins a load at base_addr
//   base_addr   in   first word address written
//   s_valid     in   stream word valid
//   s_ready     out  loader accepts a stream word (state decode only)
//   s_data      in   stream word
//   s_last      in   final word of the image
//   ram_en      out  memory port enable
//   ram_we      out  memory write enable
//   ram_addr    out  memory word address
//   ram_wdata   out  memory write data
//   pu_hold     out  holds the processing unit while loading
//   done        out  load completed without error
//   overflow    out  write attempted past the top address
//   checksum    out  running sum of accepted words (checksum build only)
//   word_count  out  words written in the current/last load
// ---------------------------------------------------------------------------
module mem_loader #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  pu_hold,
    output logic                  done,
    output logic                  overflow,
`ifdef MEM_LOADER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  accept;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] cksum_q, cksum_d;
`endif

    // A word is taken whenever the loader is in LOAD and the source offers one;
    // s_ready itself is a pure state decode, so there is no s_valid -> s_ready path.
    assign accept = (state_q == LOAD) && s_valid;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
`ifdef MEM_LOADER_CHECKSUM_EN
        cksum_d = cksum_q;
`endif
        case (state_q)
            LOAD: begin
                // start is deliberately ignored while a load is running.
                if (accept) begin
                    count_d = count_q + 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
                    cksum_d = cksum_q + s_data;
`endif
                    // The address saturates at the top instead of wrapping.
                    if (addr_q != ADDR_TOP) begin
                        addr_d = addr_q + 1'b1;
                    end
                    if (s_last) begin
                        state_d = DONE;
                    end else if (addr_q == ADDR_TOP) begin
                        state_d = ERR;
                    end
                end
            end
            default: begin // IDLE, DONE, ERR: wait for a new start
                if (start) begin
                    state_d = LOAD;
                    addr_d  = base_addr;
                    count_d = '0;
`ifdef MEM_LOADER_CHECKSUM_EN
                    cksum_d = '0;
`endif
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
            cksum_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments for all state, so every register
            // samples the pre-edge value of the others regardless of order.
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
`ifdef MEM_LOADER_CHECKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        s_ready   = (state_q == LOAD);
        ram_en    = accept;
        ram_we    = accept;
        ram_addr  = addr_q;
        ram_wdata = accept ? s_data : '0;
        done      = (state_q == DONE);
        overflow  = (state_q == ERR);
        // The hold rises in the same cycle start is sampled. The start term is
        // qualified with reset so that every output is 0 while reset is
        // asserted, even if start happens to be high.
        // NOTE: reset is a normal combinational input here; qualifying an
        // output with it does not put reset into any clocked path.
        pu_hold   = (state_q == LOAD) || (state_q == ERR) ||
                    (start && reset && (state_q != LOAD));
    end

    assign word_count = count_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    assign checksum   = cksum_q;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_loader
//   Directed bench for mem_loader. Stimulus pushes every expected memory write
//   (address, data) into a queue; an independent monitor pops and compares on
//   every write the DUT presents. Status outputs are compared directly by the
//   stimulus process against hand-computed values.
//   Compile with +define+MEM_LOADER_CHECKSUM_EN to cover the checksum output.
// ---------------------------------------------------------------------------
module tb_mem_loader;

    localparam int AW = 13;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          pu_hold;
    logic          done;
    logic          overflow;
    logic [AW:0]   word_count;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int  checks   = 0;
    int  failures = 0;
    wr_t exp_q[$];

    mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .pu_hold    (pu_hold),
        .done       (done),
        .overflow   (overflow),
`ifdef MEM_LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every memory write must match the head of the queue.
    always @(negedge clk) begin
        if (ram_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         ram_addr, ram_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_we",   ram_we,    1'b1);
                check("wr_addr", ram_addr,  e.addr);
                check("wr_data", ram_wdata, e.data);
            end
        end
    end

    // Watchdog: the bench is fixed-length, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'hDEAD_BEEF;
        s_last  = 1'b0;
    endtask

    // Pulse start for one cycle; pu_hold must already be high while start is sampled.
    task automatic do_start(input logic [AW-1:0] base);
        start     = 1'b1;
        base_addr = base;
        @(negedge clk);
        check("pu_hold_on_start", pu_hold, 1'b1);
        tick();
        start = 1'b0;
        check("s_ready_load", s_ready, 1'b1);
        check("word_count_clr", word_count, '0);
    endtask

    // Offer one word for one cycle and record the write it should cause.
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        exp_q.push_back('{addr: a, data: d});
        tick();
        idle_inputs();
    endtask

    initial begin
        reset     = 1'b0;
        base_addr = '0;
        idle_inputs();
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // ---- reset / idle state ----
        @(negedge clk);
        check("rst_s_ready",    s_ready,    1'b0);
        check("rst_pu_hold",    pu_hold,    1'b0);
        check("rst_done",       done,       1'b0);
        check("rst_overflow",   overflow,   1'b0);
        check("rst_word_count", word_count, '0);
        check("rst_ram_en",     ram_en,     1'b0);
        tick();
        check("idle_holds", s_ready, 1'b0);

        // ---- continuous 4-word image at 0x010 ----
        do_start(13'h010);
        send(13'h010, 32'h11, 1'b0);
        send(13'h011, 32'h22, 1'b0);
        send(13'h012, 32'h33, 1'b0);
        send(13'h013, 32'h44, 1'b1);
        check("t1_done",       done,       1'b1);
        check("t1_word_count", word_count, 14'd4);
        check("t1_pu_hold",    pu_hold,    1'b0);
        check("t1_s_ready",    s_ready,    1'b0);
        tick();
        check("t1_done_hold",  done,       1'b1);

        // ---- same image, s_valid on every other cycle (8 cycles) ----
        do_start(13'h010);
        check("t2_done_clr", done, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) begin
                send(13'h010 + 13'(i / 2), 32'h11 * 32'((i / 2) + 1), (i == 7));
            end else begin
                tick();
                check("t2_gap_count", word_count, 14'(i / 2));
            end
            if (i < 7) check("t2_not_done", done, 1'b0);
        end
        check("t2_done",       done,       1'b1);
        check("t2_word_count", word_count, 14'd4);

        // ---- overflow at the top of memory ----
        do_start(13'h1FFE);
        send(13'h1FFE, 32'hA5A5_0001, 1'b0);
        send(13'h1FFF, 32'hA5A5_0002, 1'b0);
        check("t3_overflow",   overflow,   1'b1);
        check("t3_done",       done,       1'b0);
        check("t3_s_ready",    s_ready,    1'b0);
        check("t3_pu_hold",    pu_hold,    1'b1);
        check("t3_word_count", word_count, 14'd2);
        check("t3_no_wrap",    ram_addr,   13'h1FFF);
        s_valid = 1'b1;             // third word offered, must not be taken
        s_data  = 32'hA5A5_0003;
        @(negedge clk);
        check("t3_third_ready", s_ready, 1'b0);
        check("t3_third_en",    ram_en,  1'b0);
        tick();
        idle_inputs();
        check("t3_err_hold", overflow, 1'b1);

        // ---- reset in the middle of a load, then clean restart ----
        do_start(13'h100);
        check("t4_overflow_clr", overflow, 1'b0);
        send(13'h100, 32'h0000_0AAA, 1'b0);
        send(13'h101, 32'h0000_0BBB, 1'b0);
        s_valid = 1'b1;
        s_data  = 32'h0000_0CCC;
        start   = 1'b1;
        reset   = 1'b0;
        #1;
        check("t4_rst_ram_en",     ram_en,     1'b0);
        check("t4_rst_ram_we",     ram_we,     1'b0);
        check("t4_rst_ram_addr",   ram_addr,   '0);
        check("t4_rst_ram_wdata",  ram_wdata,  '0);
        check("t4_rst_s_ready",    s_ready,    1'b0);
        check("t4_rst_pu_hold",    pu_hold,    1'b0);
        check("t4_rst_word_count", word_count, '0);
        check("t4_rst_done",       done,       1'b0);
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("t4_stay_idle", s_ready, 1'b0);
        do_start(13'h200);
        send(13'h200, 32'h1234_5678, 1'b0);
        send(13'h201, 32'h9ABC_DEF0, 1'b1);
        check("t4_done",       done,       1'b1);
        check("t4_word_count", word_count, 14'd2);

        // ---- start during LOAD is ignored; checksum wraps modulo 2**32 ----
        do_start(13'h020);
        send(13'h020, 32'hFFFF_FFFF, 1'b0);
        start     = 1'b1;
        base_addr = 13'h0F0;
        tick();
        start = 1'b0;
        check("t5_count_kept", word_count, 14'd1);
        check("t5_addr_kept",  ram_addr,   13'h021);
        send(13'h021, 32'h0000_0002, 1'b1);
        check("t5_done",       done,       1'b1);
        check("t5_word_count", word_count, 14'd2);
`ifdef MEM_LOADER_CHECKSUM_EN
        check("t5_checksum",   checksum,   32'h0000_0001);
`endif

        tick();
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
